// File: rtl/bus_map_if.sv
// CPU-side handshake bundle between the c86 core (master) and bus_map (slave).
// cpu_ce is the one-cycle completion pulse; cpu_i holds the last read data.
interface bus_map_if #(
  parameter int AW = 20,
  parameter int DW = 8
);
  logic          cpu_req;
  logic [AW-1:0] cpu_a;
  logic [DW-1:0] cpu_o;
  logic          cpu_w;
  logic          cpu_ce;
  logic [DW-1:0] cpu_i;

  modport master (
    output cpu_req, cpu_a, cpu_o, cpu_w,
    input  cpu_ce, cpu_i
  );

  modport slave (
    input  cpu_req, cpu_a, cpu_o, cpu_w,
    output cpu_ce, cpu_i
  );
endinterface

// File: rtl/bus_map.sv
// CPU-to-memory bus controller: base/mask region decode, per-region wait states, one-shot
// write strobes and registered read data. Define BUS_ERR_EN to enable unmapped-access logging.
module bus_map #(
  parameter int                 AW       = 20,
  parameter int                 DW       = 8,
  parameter int                 NREG     = 4,
  parameter logic [NREG*AW-1:0] REG_BASE = {20'hFF800, 20'hB8000, 20'h08000, 20'h00000},
  parameter logic [NREG*AW-1:0] REG_MASK = {20'hFF800, 20'hFE000, 20'hFF000, 20'hF8000},
  parameter logic [NREG*4-1:0]  REG_WAIT = {4'd1, 4'd0, 4'd0, 4'd0},
  parameter logic [DW-1:0]      FILL     = 8'hFF
) (
  input  logic               clock,
  input  logic               rst_n,
  bus_map_if.slave           cpu,
  output logic [AW-1:0]      mem_a,
  output logic [DW-1:0]      mem_d,
  output logic [NREG-1:0]    mem_we,
  input  logic [NREG*DW-1:0] mem_q,
  output logic [7:0]         err_cnt,
  output logic [AW-1:0]      err_addr
);

  localparam int SW = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic            mapped_q, mapped_d;
  logic            w_q, w_d;
  logic [AW-1:0]   mem_a_q, mem_a_d;
  logic [DW-1:0]   mem_d_q, mem_d_d;
  logic [NREG-1:0] mem_we_q, mem_we_d;
  logic            cpu_ce_q, cpu_ce_d;
  logic [DW-1:0]   cpu_i_q, cpu_i_d;

  logic            hit;
  logic [SW-1:0]   hit_sel;
  logic [3:0]      hit_wait;
  logic [DW-1:0]   rd_data;

  // Scan from the top region down so the lowest matching index is the one left standing.
  always_comb begin
    hit      = 1'b0;
    hit_sel  = '0;
    hit_wait = '0;
    for (int k = NREG - 1; k >= 0; k--) begin
      if ((cpu.cpu_a & REG_MASK[k*AW +: AW]) == REG_BASE[k*AW +: AW]) begin
        hit      = 1'b1;
        hit_sel  = SW'(k);
        hit_wait = REG_WAIT[k*4 +: 4];
      end
    end
  end

  always_comb begin
    rd_data = FILL;
    for (int k = 0; k < NREG; k++) begin
      if (mapped_q && (sel_q == SW'(k))) begin
        rd_data = mem_q[k*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    mapped_d = mapped_q;
    w_d      = w_q;
    mem_a_d  = mem_a_q;
    mem_d_d  = mem_d_q;
    mem_we_d = '0;
    cpu_ce_d = 1'b0;
    cpu_i_d  = cpu_i_q;

    unique case (state_q)
      IDLE: begin
        if (cpu.cpu_req) begin
          state_d  = ACC;
          mem_a_d  = cpu.cpu_a;
          mem_d_d  = cpu.cpu_o;
          w_d      = cpu.cpu_w;
          sel_d    = hit_sel;
          mapped_d = hit;
          cnt_d    = hit ? hit_wait : 4'd0;
          // Strobe is armed only on acceptance, so it is high for the first ACC cycle alone.
          for (int k = 0; k < NREG; k++) begin
            if (hit && cpu.cpu_w && (hit_sel == SW'(k))) begin
              mem_we_d[k] = 1'b1;
            end
          end
        end
      end
      ACC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d  = DONE;
          cpu_ce_d = 1'b1;
          if (!w_q) begin
            cpu_i_d = rd_data;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sel_q    <= '0;
      mapped_q <= 1'b0;
      w_q      <= 1'b0;
      mem_a_q  <= '0;
      mem_d_q  <= '0;
      mem_we_q <= '0;
      cpu_ce_q <= 1'b0;
      cpu_i_q  <= FILL;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      mapped_q <= mapped_d;
      w_q      <= w_d;
      mem_a_q  <= mem_a_d;
      mem_d_q  <= mem_d_d;
      mem_we_q <= mem_we_d;
      cpu_ce_q <= cpu_ce_d;
      cpu_i_q  <= cpu_i_d;
    end
  end

  assign cpu.cpu_ce = cpu_ce_q;
  assign cpu.cpu_i  = cpu_i_q;
  assign mem_a      = mem_a_q;
  assign mem_d      = mem_d_q;
  assign mem_we     = mem_we_q;

`ifdef BUS_ERR_EN
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic [AW-1:0] err_addr_q, err_addr_d;

  // Logged at acceptance, the same edge that moves the FSM into ACC.
  always_comb begin
    err_cnt_d  = err_cnt_q;
    err_addr_d = err_addr_q;
    if ((state_q == IDLE) && cpu.cpu_req && !hit) begin
      if (err_cnt_q != 8'hFF) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
      err_addr_d = cpu.cpu_a;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q  <= '0;
      err_addr_q <= '0;
    end else begin
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign err_cnt  = err_cnt_q;
  assign err_addr = err_addr_q;
`else
  assign err_cnt  = '0;
  assign err_addr = '0;
`endif

endmodule
